// File: rtl/debug_frame_controller.sv
// UART debug controller: decodes RX commands to run, step or breakpoint the pipeline,
// and on every halt streams a latched snapshot as a framed packet (header, data, XOR checksum).
module debug_frame_controller #(
    parameter int         NUM_BYTES = 95,
    parameter int         PC_W      = 8,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   end_of_program,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BYTES*8-1:0] snapshot,
    input  logic [7:0]             rx_data,
    input  logic                   rx_available,
    output logic                   rx_read,
    input  logic                   tx_full,
    output logic [7:0]             tx_data,
    output logic                   tx_write,
    output logic                   pipe_enable,
    output logic                   pipe_reset,
    output logic                   led_idle,
    output logic                   led_cont,
    output logic                   led_step,
    output logic                   led_send,
    output logic [15:0]            step_count
);

    localparam int BP_BYTES = (PC_W + 7) / 8;
    localparam int BP_W     = BP_BYTES * 8;
    localparam int SNAP_W   = NUM_BYTES * 8;
    localparam int IDX_W    = $clog2(NUM_BYTES + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES + 1);

    localparam logic [7:0] CH_C = 8'h63;
    localparam logic [7:0] CH_S = 8'h73;
    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_X = 8'h78;
    localparam logic [7:0] CH_H = 8'h68;
    localparam logic [7:0] CH_N = 8'h6E;
    localparam logic [7:0] CH_Q = 8'h71;

    typedef enum logic [2:0] {INIT, IDLE, ARM_BP, CONT, STEP, SNAP, SEND} state_t;

    state_t            state_q, state_d;
    logic              bp_valid_q, bp_valid_d;
    logic [BP_W-1:0]   bp_shift_q, bp_shift_d;
    logic [2:0]        bp_cnt_q, bp_cnt_d;
    logic              first_q, first_d;
    logic              ret_idle_q, ret_idle_d;
    logic [7:0]        csum_q, csum_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [15:0]       step_count_q;

    logic       bp_hit;
    logic       halt_cmd;
    logic [7:0] cur_byte;

    // The first CONT cycle ignores the breakpoint so resuming from the breakpoint PC advances.
    assign bp_hit   = bp_valid_q && (pc == bp_shift_q[PC_W-1:0]) && !first_q;
    assign halt_cmd = rx_available && (rx_data == CH_H);
    // The latched snapshot is shifted out MSB first, so the next data byte is always on top.
    assign cur_byte = snap_q[SNAP_W-1 -: 8];

    always_comb begin
        state_d     = state_q;
        bp_valid_d  = bp_valid_q;
        bp_shift_d  = bp_shift_q;
        bp_cnt_d    = bp_cnt_q;
        ret_idle_d  = ret_idle_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        rx_read     = 1'b0;
        tx_write    = 1'b0;
        tx_data     = 8'h00;
        pipe_enable = 1'b0;
        pipe_reset  = 1'b0;
        led_idle    = 1'b0;
        led_cont    = 1'b0;
        led_step    = 1'b0;
        led_send    = 1'b0;

        case (state_q)
            INIT: begin
                pipe_reset = 1'b1;
                state_d    = IDLE;
            end
            IDLE: begin
                pipe_reset = 1'b1;
                led_idle   = 1'b1;
                rx_read    = rx_available;
                if (rx_available) begin
                    case (rx_data)
                        CH_C: state_d = CONT;
                        CH_S: state_d = STEP;
                        CH_B: begin
                            state_d  = ARM_BP;
                            bp_cnt_d = 3'd0;
                        end
                        CH_X: bp_valid_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            ARM_BP: begin
                pipe_reset = 1'b1;
                led_idle   = 1'b1;
                rx_read    = rx_available;
                if (rx_available) begin
                    bp_shift_d = (bp_shift_q << 8) | BP_W'(rx_data);
                    bp_cnt_d   = bp_cnt_q + 3'd1;
                    if (bp_cnt_q == 3'(BP_BYTES - 1)) begin
                        bp_valid_d = 1'b1;
                        bp_cnt_d   = 3'd0;
                        state_d    = IDLE;
                    end
                end
            end
            CONT: begin
                led_cont    = 1'b1;
                rx_read     = rx_available;
                pipe_enable = !(end_of_program || bp_hit || halt_cmd);
                if (end_of_program || bp_hit || halt_cmd) state_d = SNAP;
            end
            STEP: begin
                led_step = 1'b1;
                rx_read  = rx_available;
                if (rx_available) begin
                    case (rx_data)
                        CH_N: begin
                            pipe_enable = 1'b1;
                            state_d     = SNAP;
                        end
                        CH_C: state_d = CONT;
                        CH_Q: state_d = IDLE;
                        default: ;
                    endcase
                end
            end
            SNAP: begin
                led_send   = 1'b1;
                snap_d     = snapshot;
                ret_idle_d = end_of_program;
                csum_d     = 8'h00;
                idx_d      = '0;
                state_d    = SEND;
            end
            SEND: begin
                led_send = 1'b1;
                tx_write = !tx_full;
                if (idx_q == '0)            tx_data = HEADER;
                else if (idx_q == LAST_IDX) tx_data = csum_q;
                else                        tx_data = cur_byte;
                if (tx_write) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ret_idle_q ? IDLE : STEP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q != '0) begin
                            csum_d = csum_q ^ cur_byte;
                            snap_d = snap_q << 8;
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase

        first_d = (state_d == CONT) && (state_q != CONT);

        // Reset overrides everything combinationally so no FIFO strobe escapes the reset cycle.
        if (reset) begin
            rx_read     = 1'b0;
            tx_write    = 1'b0;
            tx_data     = 8'h00;
            pipe_enable = 1'b0;
            pipe_reset  = 1'b1;
            led_idle    = 1'b0;
            led_cont    = 1'b0;
            led_step    = 1'b0;
            led_send    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            bp_valid_q <= 1'b0;
            bp_shift_q <= '0;
            bp_cnt_q   <= 3'd0;
            first_q    <= 1'b0;
            ret_idle_q <= 1'b0;
            csum_q     <= 8'h00;
            idx_q      <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            bp_valid_q <= bp_valid_d;
            bp_shift_q <= bp_shift_d;
            bp_cnt_q   <= bp_cnt_d;
            first_q    <= first_d;
            ret_idle_q <= ret_idle_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || pipe_reset) step_count_q <= 16'h0000;
        else if (pipe_enable)    step_count_q <= step_count_q + 16'h0001;
    end

    assign step_count = reset ? 16'h0000 : step_count_q;

endmodule

// File: doc/debug_frame_controller.md
Name: debug_frame_controller

Overview:
- Parametrised UART debug controller for the pipelined datapath.
- Decodes ASCII commands from the UART RX FIFO and gates the pipeline through continuous, step and breakpoint modes.
- On every halt it latches a full pipeline/register snapshot in one cycle and streams it to the UART TX FIFO as a framed packet: header, data bytes, XOR checksum.
- Sits between the UART FIFOs and the datapath. It replaces the fixed-size debug unit with a width-generic, flow-controlled, breakpoint-capable version.

Parameters:
- NUM_BYTES, 95, number of snapshot data bytes per frame (1..254).
- PC_W, 8, program-counter width in bits (1..32).
- HEADER, 8'hA5, frame start byte.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- end_of_program  in  1  datapath reports that the program has finished.
- pc  in  PC_W  current fetch PC.
- snapshot  in  NUM_BYTES*8  flattened debug data. Byte 0 is snapshot[NUM_BYTES*8-1 -: 8].
- rx_data  in  8  head of the RX FIFO (first-word fall-through).
- rx_available  in  1  RX FIFO not empty.
- rx_read  out  1  pop RX FIFO this cycle.
- tx_full  in  1  TX FIFO full.
- tx_data  out  8  byte to TX FIFO.
- tx_write  out  1  push tx_data this cycle.
- pipe_enable  out  1  pipeline advances this cycle.
- pipe_reset  out  1  hold the pipeline in reset.
- led_idle, led_cont, led_step, led_send  out  1 each  state indicators.
- step_count  out  16  count of pipe_enable cycles since the last pipe_reset.

Behaviour:

States: INIT, IDLE, ARM_BP, CONT, STEP, SNAP, SEND. State register is synchronous; rx_read, tx_write and pipe_enable are combinational from state and inputs.

Reset (any state, including mid-SEND):
- Next state INIT; bp_valid=0; step_count=0; byte index=0.
- All outputs 0 except pipe_reset=1.
- INIT lasts 1 cycle, then IDLE.

Command consumption:
- rx_read=1 for exactly one cycle in which rx_available=1 and the state accepts commands (IDLE, ARM_BP, CONT, STEP).
- Unrecognised characters are consumed and ignored.

IDLE:
- pipe_reset=1, pipe_enable=0, led_idle=1.
- "c" -> CONT; "s" -> STEP; "b" -> ARM_BP; "x" -> bp_valid=0.

ARM_BP:
- led_idle=1; pipe_reset=1.
- Collects ceil(PC_W/8) bytes, MSB first, into bp_addr (upper excess bits discarded).
- After the last byte: bp_valid=1, return to IDLE.

CONT:
- pipe_reset=0, led_cont=1.
- pipe_enable = !(end_of_program | bp_hit | halt_cmd).
  - bp_hit = bp_valid & pc==bp_addr, masked during the first CONT cycle so a resume from a breakpoint PC always advances.
  - halt_cmd = rx_available & rx_data=="h"; the "h" is consumed.
- Any of those three conditions -> SNAP with the PC frozen.

STEP:
- pipe_reset=0, led_step=1.
- "n": pipe_enable=1 for exactly that cycle, then SNAP.
- "c" -> CONT.
- "q" -> IDLE.

SNAP (1 cycle):
- led_send=1, pipe_enable=0.
- Latches snapshot into an internal register (sent bytes are coherent).
- Records ret_idle=end_of_program; clears checksum; index=0. Next state is SEND.

SEND:
- led_send=1; pipe_enable=0; RX is not read.
- Frame length is NUM_BYTES+2: index 0 = HEADER, 1..NUM_BYTES = latched bytes 0..NUM_BYTES-1, NUM_BYTES+1 = checksum.
- The checksum is the XOR of all data bytes; the header is excluded.
- tx_write = !tx_full. The index advances only on a write.
- While tx_full=1, tx_data holds its value and no byte is skipped or duplicated.
- After the checksum is written: ret_idle ? IDLE : STEP. A breakpoint or "h" halt in CONT therefore lands in STEP.

step_count:
- +1 on every pipe_enable cycle; wraps 0xFFFF -> 0x0000.
- Cleared while pipe_reset=1.

Boundaries:
- end_of_program asserted in STEP during "n": a frame is still sent, then IDLE.
- bp_hit and end_of_program in the same cycle: a single frame, then IDLE.
- NUM_BYTES=1: frame is 3 bytes.

Test Plan:
- NUM_BYTES=4, snapshot=32'h11223344: send "s", then "n" -> exactly one pipe_enable pulse, then TX bytes A5 11 22 33 44 44, then back in STEP (led_step=1).
- Same setup, tx_full held high for 5 cycles in the middle of byte 2 -> no tx_write while full; the received stream is still exactly A5 11 22 33 44 44.
- Change snapshot to 32'hFFFFFFFF during SEND -> the frame still carries 11 22 33 44 (latched in SNAP).
- PC_W=8: "b",0x0C,"c" with pc counting by 4 -> pipe_enable falls in the cycle pc==0x0C; one frame; STEP state. Then "c" -> pipe_enable high in the first CONT cycle; pc advances to 0x10.
- "c" with end_of_program rising at cycle 20 -> step_count=19; one frame; IDLE with pipe_reset=1 and step_count=0.
- Assert reset during SEND at byte 3 -> tx_write=0 from the next cycle; INIT, then IDLE; bp_valid=0; subsequent "s","n" produces a full fresh frame.
